// File: rtl/spi_slave_port_if.sv
// CPU-side register bus of spi_slave_port: address, data, chipselect and
// strobes plus the interrupt and ready indications.
// The SPI pins and clk/reset_n are plain ports of the block.
interface spi_slave_port_if;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;
    logic        spi_select;
    logic        read_n;
    logic        write_n;
    logic        irq;
    logic        dataavailable;
    logic        readyfordata;

    // CPU / bus master side
    modport master (
        output mem_addr, data_from_cpu, spi_select, read_n, write_n,
        input  data_to_cpu, irq, dataavailable, readyfordata
    );

    // SPI slave port side
    modport slave (
        input  mem_addr, data_from_cpu, spi_select, read_n, write_n,
        output data_to_cpu, irq, dataavailable, readyfordata
    );
endinterface

// File: rtl/spi_slave_port.sv
// SPI slave (CPOL=0, CPHA=0, MSB first) with a small CPU register file:
// rxdata, txdata, status and control, plus a registered interrupt.
// SCLK, SS_n and MOSI are oversampled by clk through SYNC_STAGES flops.
// Optional build macro SPI_SLAVE_MISO_TRISTATE_EN: MISO floats when the
// port is not shifting; without it MISO drives 0 in that case.
module spi_slave_port #(
    parameter int DATABITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           SCLK,
    input  logic           SS_n,
    input  logic           MOSI,
    output logic           MISO,
    spi_slave_port_if.slave bus
);

    localparam logic [15:0] CTRL_MASK = 16'h01D8;
    localparam logic [2:0]  LAST_BIT  = 3'(DATABITS - 1);

    // LOCKED: SS_n was already low when reset released; the port waits for
    // SS_n to go high so a transfer only starts on a genuine falling edge.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_d, ss_d;
    logic [SYNC_STAGES:0]   sync_ok;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall;

    logic [DATABITS-1:0] rx_shift, rx_holding, tx_shift, tx_holding;
    logic [2:0]          bitcnt;
    logic                primed, rrdy, roe, toe;
    logic [15:0]         ctrl;
    logic [15:0]         status, rd_data;
    logic                trdy, tmt;

    logic start, abort, rx_bit, tx_edge, byte_done, load_tx;
    logic bus_wr, bus_rd, tx_wr, status_wr, ctrl_wr, rx_rd;

    // Synchronize the SPI inputs and keep one extra delayed copy for edges.
    // NOTE: every sequential block uses non-blocking (<=) assignments so all
    // flops sample the pre-edge values and simulation matches hardware.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
            sync_ok   <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
            sync_ok   <= {sync_ok[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and per-cycle shift strobes. sync_ok's top bit means both
    // ss_s and ss_d hold real samples, so the reset value cannot fake a fall.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        abort     = 1'b0;
        rx_bit    = 1'b0;
        tx_edge   = 1'b0;
        unique case (state)
            IDLE: begin
                if (sync_ok[SYNC_STAGES] && !ss_s) begin
                    if (ss_d) begin
                        state_nxt = ACTIVE;
                        start     = 1'b1;
                    end else begin
                        state_nxt = LOCKED;
                    end
                end
            end
            ACTIVE: begin
                if (ss_s) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else begin
                    rx_bit  = sclk_rise;
                    tx_edge = sclk_fall;
                end
            end
            LOCKED: begin
                if (ss_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign byte_done = rx_bit & (bitcnt == LAST_BIT);
    assign load_tx   = start | (tx_edge & (bitcnt == 3'd0));

    assign bus_wr    = bus.spi_select & ~bus.write_n;
    assign bus_rd    = bus.spi_select & ~bus.read_n;
    assign tx_wr     = bus_wr & (bus.mem_addr == 3'd1);
    assign status_wr = bus_wr & (bus.mem_addr == 3'd2);
    assign ctrl_wr   = bus_wr & (bus.mem_addr == 3'd3);
    assign rx_rd     = bus_rd & (bus.mem_addr == 3'd0);

    assign trdy   = ~primed;
    assign tmt    = ~primed & (state == IDLE);
    assign status = {7'd0, roe | toe, rrdy, trdy, tmt, toe, roe, 3'd0};

    // Read data multiplexer; txdata and unused addresses read as zero.
    always_comb begin
        rd_data = 16'd0;
        case (bus.mem_addr)
            3'd0:    rd_data = {{(16-DATABITS){1'b0}}, rx_holding};
            3'd2:    rd_data = status;
            3'd3:    rd_data = ctrl;
            default: rd_data = 16'd0;
        endcase
    end

    // Shift datapath, flags, control register and registered bus outputs.
    // Where a flag is set and cleared in the same cycle the set branch wins.
    // NOTE: these are plain control/data registers, not a memory array, so
    // each one gets a defined reset value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bitcnt      <= 3'd0;
            rx_shift    <= '0;
            rx_holding  <= '0;
            tx_shift    <= '0;
            tx_holding  <= '0;
            primed      <= 1'b0;
            rrdy        <= 1'b0;
            roe         <= 1'b0;
            toe         <= 1'b0;
            ctrl        <= 16'd0;
            bus.data_to_cpu <= 16'd0;
            bus.irq     <= 1'b0;
        end else begin
            if (start || abort) bitcnt <= 3'd0;
            else if (rx_bit)    bitcnt <= bitcnt + 3'd1;

            if (rx_bit)    rx_shift   <= {rx_shift[DATABITS-2:0], mosi_s};
            if (byte_done) rx_holding <= {rx_shift[DATABITS-2:0], mosi_s};

            if (load_tx)      tx_shift <= primed ? tx_holding : '0;
            else if (tx_edge) tx_shift <= {tx_shift[DATABITS-2:0], 1'b0};

            // primed is only cleared by a load while set and only set by a
            // write while clear, so the two never collide.
            if (load_tx && primed)      primed <= 1'b0;
            else if (tx_wr && !primed)  primed <= 1'b1;

            if (tx_wr && !primed) tx_holding <= bus.data_from_cpu[DATABITS-1:0];

            if (tx_wr && primed) toe <= 1'b1;
            else if (status_wr)  toe <= 1'b0;

            if (byte_done && rrdy) roe <= 1'b1;
            else if (status_wr)    roe <= 1'b0;

            if (byte_done)  rrdy <= 1'b1;
            else if (rx_rd) rrdy <= 1'b0;

            if (ctrl_wr) ctrl <= bus.data_from_cpu & CTRL_MASK;

            if (bus_rd) bus.data_to_cpu <= rd_data;

            bus.irq <= |(status & ctrl);
        end
    end

    assign bus.dataavailable = rrdy;
    assign bus.readyfordata  = trdy;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign MISO = (state == ACTIVE) ? tx_shift[DATABITS-1] : 1'bz;
`else
    assign MISO = (state == ACTIVE) ? tx_shift[DATABITS-1] : 1'b0;
`endif

endmodule
